decode_scoreboard: RTL and testbench

- Parametrised decode-stage hazard unit and output register.
- Tracks a per-register count of in-flight writes and stalls fetch while any used source operand has pending writes.
- Holds one decoded instruction for the execute stage behind a valid/ready handshake.
- Sits between fetch/decoder and execute; write-back stages report completions on NRET retire ports.

---
 rtl/decode_scoreboard_pkg.sv | 15 +
 rtl/decode_scoreboard_sb_counter_bank.sv | 72 +++++++
 rtl/decode_scoreboard.sv | 107 ++++++++++
 tb/tb_decode_scoreboard.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_scoreboard_pkg.sv
// rtl/decode_scoreboard_pkg.sv - shared types and constants for the decode scoreboard
package decode_scoreboard_pkg;
  localparam int SB_NREG      = 32;
  localparam int SB_CNT_W     = 2;
  localparam int SB_PAYLOAD_W = 64;

  typedef logic [4:0]          creg_addr_t;
  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

  typedef struct packed {
    creg_addr_t              dst;
    logic                    wen;
    logic [SB_PAYLOAD_W-1:0] payload;
  } decode_issue_t;
endpackage

// File: rtl/decode_scoreboard_sb_counter_bank.sv
// rtl/decode_scoreboard_sb_counter_bank.sv - per-register pending-write counters with retire reduction
module sb_counter_bank
  import decode_scoreboard_pkg::*;
#(
  parameter int NRET  = 3,
  parameter int CNT_W = 2,
  parameter int HIT_W = $clog2(NRET + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NRET-1:0]  ret_valid,
  input  logic [NRET*5-1:0] ret_dst,
  input  logic             inc_en,
  input  creg_addr_t       inc_dst,
  input  logic             flush_en,
  input  creg_addr_t       flush_dst,
  output logic [CNT_W-1:0] pend [SB_NREG],
  output logic [HIT_W-1:0] ret_hits [SB_NREG],
  output logic             busy,
  output logic             err_underflow
);
  localparam int AW = CNT_W + 2;

  logic [CNT_W-1:0] pend_q [SB_NREG];
  logic [CNT_W-1:0] pend_d [SB_NREG];
  logic             err_q;
  logic             err_d;
  logic [AW-1:0]    sum_v;
  logic [AW-1:0]    dec_v;

  always_comb begin
    err_d = err_q;
    sum_v = '0;
    dec_v = '0;
    for (int r = 0; r < SB_NREG; r++) begin
      ret_hits[r] = '0;
      for (int k = 0; k < NRET; k++) begin
        if (ret_valid[k] && ret_dst[5*k +: 5] == creg_addr_t'(r))
          ret_hits[r] = ret_hits[r] + HIT_W'(1);
      end
      sum_v = AW'(pend_q[r]) + AW'(inc_en && inc_dst == creg_addr_t'(r));
      dec_v = AW'(ret_hits[r]) + AW'(flush_en && flush_dst == creg_addr_t'(r));
      // x0 is hardwired zero, so it is never tracked and never flags underflow
      if (r == 0) begin
        pend_d[r] = '0;
      end else if (dec_v > sum_v) begin
        pend_d[r] = '0;
        err_d     = 1'b1;
      end else begin
        pend_d[r] = CNT_W'(sum_v - dec_v);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int r = 0; r < SB_NREG; r++) pend_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 0; r < SB_NREG; r++) busy = busy | (|pend_q[r]);
  end

  assign pend          = pend_q;
  assign err_underflow = err_q;
endmodule

// File: rtl/decode_scoreboard.sv
// rtl/decode_scoreboard.sv - decode-stage RAW/structural hazard unit with issue register
module decode_scoreboard
  import decode_scoreboard_pkg::*;
#(
  parameter int NSRC       = 2,
  parameter int NRET       = 3,
  parameter int CNT_W      = 2,
  parameter int PAYLOAD_W  = 64,
  parameter int RET_BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NSRC*5-1:0]    in_src,
  input  logic [NSRC-1:0]      in_src_used,
  input  logic [4:0]           in_dst,
  input  logic                 in_wen,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [4:0]           out_dst,
  output logic                 out_wen,
  input  logic [NRET-1:0]      ret_valid,
  input  logic [NRET*5-1:0]    ret_dst,
  input  logic                 flush,
  output logic                 busy,
  output logic                 err_underflow
);
  localparam int HIT_W = $clog2(NRET + 1);

  typedef struct packed {
    creg_addr_t           dst;
    logic                 wen;
    logic [PAYLOAD_W-1:0] payload;
  } issue_t;

  logic [CNT_W-1:0] pend [SB_NREG];
  logic [HIT_W-1:0] ret_hits [SB_NREG];
  issue_t           out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             src_hazard, struct_hazard, fire, flush_dec;
  creg_addr_t       src_a;

  always_comb begin
    src_hazard = 1'b0;
    src_a      = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_a = in_src[5*i +: 5];
      // bypass: every outstanding write to this source retires this very cycle
      if (in_src_used[i] && src_a != '0 && pend[src_a] != '0 &&
          !(RET_BYPASS != 0 && 32'(pend[src_a]) == 32'(ret_hits[src_a])))
        src_hazard = 1'b1;
    end
    struct_hazard = in_wen && in_dst != '0 && pend[in_dst] == '1 && ret_hits[in_dst] == '0;
    in_ready  = resetn && !flush && (!out_valid_q || out_ready) && !src_hazard && !struct_hazard;
    fire      = in_valid && in_ready;
    // a flushed, unconsumed entry never reaches write-back, so its count is dropped here
    flush_dec = flush && out_valid_q && !out_ready && out_q.wen && out_q.dst != '0;

    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (fire) begin
      out_d.dst     = in_dst;
      out_d.wen     = in_wen;
      out_d.payload = in_payload;
      out_valid_d   = 1'b1;
    end else if (flush || out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  sb_counter_bank #(
    .NRET  (NRET),
    .CNT_W (CNT_W),
    .HIT_W (HIT_W)
  ) u_bank (
    .clk           (clk),
    .resetn        (resetn),
    .ret_valid     (ret_valid),
    .ret_dst       (ret_dst),
    .inc_en        (fire && in_wen),
    .inc_dst       (in_dst),
    .flush_en      (flush_dec),
    .flush_dst     (out_q.dst),
    .pend          (pend),
    .ret_hits      (ret_hits),
    .busy          (busy),
    .err_underflow (err_underflow)
  );

  assign out_valid   = out_valid_q;
  assign out_payload = out_q.payload;
  assign out_dst     = out_q.dst;
  assign out_wen     = out_q.wen;
endmodule

// File: tb/tb_decode_scoreboard.sv
// tb/tb_decode_scoreboard.sv - directed self-checking bench for decode_scoreboard
module tb_decode_scoreboard;
  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_src;
  logic [1:0]  in_src_used;
  logic [4:0]  in_dst;
  logic        in_wen;
  logic [63:0] in_payload;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_payload;
  logic [4:0]  out_dst;
  logic        out_wen;
  logic [2:0]  ret_valid;
  logic [14:0] ret_dst;
  logic        flush;
  logic        busy;
  logic        err_underflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decode_scoreboard dut (
    .clk           (clk),
    .resetn        (resetn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_src        (in_src),
    .in_src_used   (in_src_used),
    .in_dst        (in_dst),
    .in_wen        (in_wen),
    .in_payload    (in_payload),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_payload   (out_payload),
    .out_dst       (out_dst),
    .out_wen       (out_wen),
    .ret_valid     (ret_valid),
    .ret_dst       (ret_dst),
    .flush         (flush),
    .busy          (busy),
    .err_underflow (err_underflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] dst, input logic wen, input logic [9:0] src,
                       input logic [1:0] used, input logic [63:0] pl);
    in_valid    = 1'b1;
    in_dst      = dst;
    in_wen      = wen;
    in_src      = src;
    in_src_used = used;
    in_payload  = pl;
  endtask

  task automatic idle_in();
    in_valid    = 1'b0;
    in_wen      = 1'b0;
    in_dst      = '0;
    in_src      = '0;
    in_src_used = '0;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; out_ready = 1'b1;
    ret_valid = '0; ret_dst = '0; in_payload = '0;
    idle_in();
    in_valid = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 0);
    step();
    check("rst_in_ready2", in_ready, 0);
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_payload", out_payload, 0);
    resetn = 1'b1;
    idle_in();
    step();
    check("idle_out_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_err", err_underflow, 0);
    check("idle_in_ready", in_ready, 1);

    // RAW stall on x5 released by a same-cycle retire on port 1
    offer(5'd5, 1'b1, 10'd0, 2'b00, 64'hA5A5_0001);
    #1 check("raw_issue_ready", in_ready, 1);
    step();
    check("raw_out_valid", out_valid, 1);
    check("raw_out_payload", out_payload, 64'hA5A5_0001);
    check("raw_out_dst", out_dst, 5);
    check("raw_busy", busy, 1);
    offer(5'd0, 1'b0, {5'd0, 5'd5}, 2'b01, 64'hB0B0_0002);
    #1 check("raw_stall", in_ready, 0);
    step();
    check("raw_drain", out_valid, 0);
    ret_valid = 3'b010; ret_dst = {5'd0, 5'd5, 5'd0};
    #1 check("raw_bypass_ready", in_ready, 1);
    step();
    check("raw_bypass_payload", out_payload, 64'hB0B0_0002);
    check("raw_pend5", dut.pend[5], 0);
    check("raw_busy_clear", busy, 0);
    ret_valid = '0;

    // three writes in flight to x7, fourth is a structural stall
    for (int n = 0; n < 3; n++) begin
      offer(5'd7, 1'b1, 10'd0, 2'b00, 64'(n));
      #1 check("multi_issue_ready", in_ready, 1);
      step();
    end
    check("multi_pend7", dut.pend[7], 3);
    offer(5'd7, 1'b1, 10'd0, 2'b00, 64'h44);
    #1 check("multi_struct_stall", in_ready, 0);
    step();
    ret_valid = 3'b011; ret_dst = {5'd0, 5'd7, 5'd7};
    #1 check("multi_retire_ready", in_ready, 1);
    step();
    check("multi_pend7_after", dut.pend[7], 2);
    check("multi_fourth_payload", out_payload, 64'h44);
    idle_in();
    step();
    check("multi_pend7_drained", dut.pend[7], 0);
    check("multi_busy_clear", busy, 0);
    ret_valid = '0;

    // simultaneous issue and retire of x9; unused src1=x9 does not stall
    offer(5'd9, 1'b1, 10'd0, 2'b00, 64'h90);
    step();
    offer(5'd9, 1'b1, {5'd9, 5'd0}, 2'b01, 64'h91);
    ret_valid = 3'b100; ret_dst = {5'd9, 5'd0, 5'd0};
    #1 check("x9_unused_ready", in_ready, 1);
    step();
    check("x9_pend_net", dut.pend[9], 1);
    idle_in();
    step();
    check("x9_pend_zero", dut.pend[9], 0);
    ret_valid = '0;

    // flush of an unconsumed held write to x3 drops its count
    offer(5'd3, 1'b1, 10'd0, 2'b00, 64'h33);
    step();
    idle_in();
    out_ready = 1'b0;
    step();
    check("hold_out_valid", out_valid, 1);
    flush = 1'b1;
    #1 check("flush_in_ready", in_ready, 0);
    step();
    check("flush_out_valid", out_valid, 0);
    check("flush_pend3_dropped", dut.pend[3], 0);
    flush = 1'b0; out_ready = 1'b1;
    offer(5'd3, 1'b1, 10'd0, 2'b00, 64'h34);
    step();
    idle_in();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_consumed_valid", out_valid, 0);
    check("flush_consumed_pend3", dut.pend[3], 1);
    ret_valid = 3'b001; ret_dst = {5'd0, 5'd0, 5'd3};
    step();
    ret_valid = '0;
    check("flush_pend3_retired", dut.pend[3], 0);

    // x0 handling and underflow
    ret_valid = 3'b001; ret_dst = '0;
    step();
    check("x0_retire_no_err", err_underflow, 0);
    ret_valid = '0;
    offer(5'd0, 1'b1, 10'd0, 2'b00, 64'h0);
    step();
    idle_in();
    check("x0_write_busy", busy, 0);
    ret_valid = 3'b001; ret_dst = {5'd0, 5'd0, 5'd12};
    step();
    ret_valid = '0;
    check("underflow_pend12", dut.pend[12], 0);
    check("underflow_err", err_underflow, 1);
    step();
    check("underflow_sticky", err_underflow, 1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("underflow_reset", err_underflow, 0);
    check("final_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
